// File: rtl/nvme_pkg.sv
// Shared definitions for the NVMe submission-queue writer: entry layout,
// doorbell placement, FSM state encoding and the dword packing helper.
package nvme_pkg;

    localparam int SQE_BYTES  = 64;
    localparam int SQE_DWORDS = SQE_BYTES / 4;

    localparam logic [3:0] DW_CDW0    = 4'd0;
    localparam logic [3:0] DW_NSID    = 4'd1;
    localparam logic [3:0] DW_MPTR_LO = 4'd4;
    localparam logic [3:0] DW_MPTR_HI = 4'd5;
    localparam logic [3:0] DW_PRP1_LO = 4'd6;
    localparam logic [3:0] DW_PRP1_HI = 4'd7;
    localparam logic [3:0] DW_PRP2_LO = 4'd8;
    localparam logic [3:0] DW_PRP2_HI = 4'd9;
    localparam logic [3:0] DW_CDW10   = 4'd10;
    localparam logic [3:0] DW_CDW11   = 4'd11;
    localparam logic [3:0] DW_CDW12   = 4'd12;
    localparam logic [3:0] DW_CDW13   = 4'd13;
    localparam logic [3:0] DW_CDW14   = 4'd14;
    localparam logic [3:0] DW_LAST    = 4'd15;

    localparam logic [31:0] SQ_DB_OFFSET = 32'h0000_1000;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_CAPTURE  = 5'b00010,
        ST_WRITE_DW = 5'b00100,
        ST_DOORBELL = 5'b01000,
        ST_DONE     = 5'b10000
    } sq_state_e;

    typedef struct packed {
        logic [7:0]  opc;
        logic [7:0]  psdt_fuse;
        logic [15:0] cid;
        logic [31:0] nsid;
        logic [63:0] mptr;
        logic [63:0] prp1;
        logic [63:0] prp2;
        logic [31:0] cdw10;
        logic [31:0] cdw11;
        logic [31:0] cdw12;
        logic [31:0] cdw13;
        logic [31:0] cdw14;
        logic [31:0] cdw15;
    } sq_cmd_t;

    // SQ1 sits two doorbell slots above SQ0 (the CQ0 head doorbell lies between).
    function automatic logic [31:0] sq_doorbell_addr(input logic [31:0] bar0,
                                                     input int dstrd,
                                                     input logic io_queue);
        return bar0 + SQ_DB_OFFSET + (io_queue ? (32'd8 << dstrd) : 32'd0);
    endfunction

    function automatic logic [31:0] sqe_dword(input sq_cmd_t cmd, input logic [3:0] k);
        logic [31:0] dw;
        case (k)
            DW_CDW0:    dw = {cmd.cid, cmd.psdt_fuse, cmd.opc};
            DW_NSID:    dw = cmd.nsid;
            DW_MPTR_LO: dw = cmd.mptr[31:0];
            DW_MPTR_HI: dw = cmd.mptr[63:32];
            DW_PRP1_LO: dw = cmd.prp1[31:0];
            DW_PRP1_HI: dw = cmd.prp1[63:32];
            DW_PRP2_LO: dw = cmd.prp2[31:0];
            DW_PRP2_HI: dw = cmd.prp2[63:32];
            DW_CDW10:   dw = cmd.cdw10;
            DW_CDW11:   dw = cmd.cdw11;
            DW_CDW12:   dw = cmd.cdw12;
            DW_CDW13:   dw = cmd.cdw13;
            DW_CDW14:   dw = cmd.cdw14;
            DW_LAST:    dw = cmd.cdw15;
            default:    dw = 32'd0;
        endcase
        return dw;
    endfunction

endpackage

// File: rtl/nvme_sq_writer_if.sv
// Host-memory dword write channel and controller doorbell register channel.
interface nvme_sq_writer_if;

    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [63:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        db_wr_valid;
    logic        db_wr_ready;
    logic [31:0] db_wr_addr;
    logic [31:0] db_wr_data;

    modport master (
        output mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  mem_wr_ready,
        output db_wr_valid, db_wr_addr, db_wr_data,
        input  db_wr_ready
    );

    modport slave (
        input  mem_wr_valid, mem_wr_addr, mem_wr_data,
        output mem_wr_ready,
        input  db_wr_valid, db_wr_addr, db_wr_data,
        output db_wr_ready
    );

endinterface

// File: rtl/nvme_sq_tail.sv
// Tail pointer of one submission queue with wrap at DEPTH and a full flag
// compared against a registered copy of the consumer head.
module nvme_sq_tail #(
    parameter logic [15:0] DEPTH = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] head,
    input  logic        advance,
    output logic [15:0] tail,
    output logic [15:0] next_tail,
    output logic        full
);

    logic [15:0] tail_q, tail_d;
    logic [15:0] head_q, head_d;

    always_comb begin
        next_tail = (tail_q == DEPTH - 16'd1) ? 16'd0 : tail_q + 16'd1;
        tail_d    = advance ? next_tail : tail_q;
        head_d    = head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_q <= 16'd0;
            head_q <= 16'd0;
        end else begin
            tail_q <= tail_d;
            head_q <= head_d;
        end
    end

    assign tail = tail_q;
    assign full = (next_tail == head_q);

endmodule

// File: rtl/nvme_sq_writer.sv
// Packs one decoded NVMe command into a 64-byte SQ entry, writes it as 16 dwords,
// then rings the admin or I/O SQ tail doorbell and reports completion.
module nvme_sq_writer
    import nvme_pkg::*;
#(
    parameter logic [63:0] ASQ_ADDR    = 64'h0000_0000_a010_0000,
    parameter logic [63:0] IOSQ_ADDR   = 64'h0000_0000_a010_2000,
    parameter logic [15:0] ADMIN_DEPTH = 16'd64,
    parameter logic [15:0] IO_DEPTH    = 16'd64,
    parameter logic [31:0] BAR0_ADDR   = 32'h0000_0000,
    parameter int          DSTRD       = 0
) (
    input  logic                    clk_in,
    input  logic                    resetb,
    input  logic                    write_start,
    output logic                    write_start_ack,
    input  logic                    is_io_queue,
    input  logic [7:0]              admin_opc,
    input  logic [7:0]              PSDT_FUSE,
    input  logic [15:0]             cid,
    input  logic [31:0]             nsid,
    input  logic [63:0]             MPTR,
    input  logic [63:0]             PRP1,
    input  logic [63:0]             PRP2,
    input  logic [31:0]             CDW10,
    input  logic [31:0]             CDW11,
    input  logic [31:0]             CDW12,
    input  logic [31:0]             CDW13,
    input  logic [31:0]             CDW14,
    input  logic [31:0]             CDW15,
    input  logic [15:0]             admin_sq_head,
    input  logic [15:0]             io_sq_head,
    nvme_sq_writer_if.master        bus,
    output logic                    seq_tail_done,
    output logic                    seq_tail_done_ack,
    output logic                    iosq_tail_done,
    output logic                    iosq_tail_done_ack,
    output logic [15:0]             admin_create_queue_cnt,
    output logic [15:0]             io_create_queue_cnt,
    output logic                    sq_full
);

    sq_state_e   state_q, state_d;
    sq_cmd_t     cmd_q, cmd_d;
    logic        is_io_q, is_io_d;
    logic [63:0] base_q, base_d;
    logic [3:0]  beat_q, beat_d;
    logic        armed_q, armed_d;
    logic        ack_q, ack_d;
    logic        mem_valid_q, mem_valid_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        db_valid_q, db_valid_d;
    logic [31:0] db_addr_q, db_addr_d;
    logic [31:0] db_data_q, db_data_d;
    logic        admin_done_q, admin_done_d;
    logic        io_done_q, io_done_d;
    logic        sq_full_q, sq_full_d;

    logic [15:0] admin_tail, admin_next, io_tail, io_next;
    logic        admin_full, io_full;
    logic        db_fire;
    logic [15:0] sel_tail, sel_next;
    logic        req_full, accept;
    logic [3:0]  next_beat;

    assign db_fire = (state_q == ST_DOORBELL) && db_valid_q && bus.db_wr_ready;

    nvme_sq_tail #(.DEPTH(ADMIN_DEPTH)) u_admin_tail (
        .clk       (clk_in),
        .rst_n     (resetb),
        .head      (admin_sq_head),
        .advance   (db_fire && !is_io_q),
        .tail      (admin_tail),
        .next_tail (admin_next),
        .full      (admin_full)
    );

    nvme_sq_tail #(.DEPTH(IO_DEPTH)) u_io_tail (
        .clk       (clk_in),
        .rst_n     (resetb),
        .head      (io_sq_head),
        .advance   (db_fire && is_io_q),
        .tail      (io_tail),
        .next_tail (io_next),
        .full      (io_full)
    );

    // A request held high across a whole command must be dropped before it can start another.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        is_io_d      = is_io_q;
        base_d       = base_q;
        beat_d       = beat_q;
        armed_d      = armed_q | ~write_start;
        ack_d        = 1'b0;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        db_valid_d   = db_valid_q;
        db_addr_d    = db_addr_q;
        db_data_d    = db_data_q;
        admin_done_d = 1'b0;
        io_done_d    = 1'b0;
        sq_full_d    = 1'b0;
        sel_tail     = is_io_q ? io_tail : admin_tail;
        sel_next     = is_io_q ? io_next : admin_next;
        req_full     = is_io_queue ? io_full : admin_full;
        accept       = write_start && armed_q && !req_full;
        next_beat    = beat_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                sq_full_d = write_start && armed_q && req_full;
                if (accept) begin
                    cmd_d.opc       = admin_opc;
                    cmd_d.psdt_fuse = PSDT_FUSE;
                    cmd_d.cid       = cid;
                    cmd_d.nsid      = nsid;
                    cmd_d.mptr      = MPTR;
                    cmd_d.prp1      = PRP1;
                    cmd_d.prp2      = PRP2;
                    cmd_d.cdw10     = CDW10;
                    cmd_d.cdw11     = CDW11;
                    cmd_d.cdw12     = CDW12;
                    cmd_d.cdw13     = CDW13;
                    cmd_d.cdw14     = CDW14;
                    cmd_d.cdw15     = CDW15;
                    is_io_d         = is_io_queue;
                    armed_d         = 1'b0;
                    ack_d           = 1'b1;
                    state_d         = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                base_d  = (is_io_q ? IOSQ_ADDR : ASQ_ADDR) + ({48'd0, sel_tail} << 6);
                beat_d  = 4'd0;
                state_d = ST_WRITE_DW;
            end
            ST_WRITE_DW: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = base_q + {58'd0, beat_q, 2'b00};
                    mem_data_d  = sqe_dword(cmd_q, beat_q);
                end else if (bus.mem_wr_ready) begin
                    if (beat_q == DW_LAST) begin
                        mem_valid_d = 1'b0;
                        db_valid_d  = 1'b1;
                        db_addr_d   = sq_doorbell_addr(BAR0_ADDR, DSTRD, is_io_q);
                        db_data_d   = {16'd0, sel_next};
                        state_d     = ST_DOORBELL;
                    end else begin
                        beat_d     = next_beat;
                        mem_addr_d = base_q + {58'd0, next_beat, 2'b00};
                        mem_data_d = sqe_dword(cmd_q, next_beat);
                    end
                end
            end
            ST_DOORBELL: begin
                if (bus.db_wr_ready) begin
                    db_valid_d   = 1'b0;
                    admin_done_d = !is_io_q;
                    io_done_d    = is_io_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            is_io_q      <= 1'b0;
            base_q       <= 64'd0;
            beat_q       <= 4'd0;
            armed_q      <= 1'b1;
            ack_q        <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_data_q   <= 32'd0;
            db_valid_q   <= 1'b0;
            db_addr_q    <= 32'd0;
            db_data_q    <= 32'd0;
            admin_done_q <= 1'b0;
            io_done_q    <= 1'b0;
            sq_full_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            is_io_q      <= is_io_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            armed_q      <= armed_d;
            ack_q        <= ack_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            db_valid_q   <= db_valid_d;
            db_addr_q    <= db_addr_d;
            db_data_q    <= db_data_d;
            admin_done_q <= admin_done_d;
            io_done_q    <= io_done_d;
            sq_full_q    <= sq_full_d;
        end
    end

    assign write_start_ack        = ack_q;
    assign bus.mem_wr_valid       = mem_valid_q;
    assign bus.mem_wr_addr        = mem_addr_q;
    assign bus.mem_wr_data        = mem_data_q;
    assign bus.db_wr_valid        = db_valid_q;
    assign bus.db_wr_addr         = db_addr_q;
    assign bus.db_wr_data         = db_data_q;
    assign seq_tail_done          = admin_done_q;
    assign seq_tail_done_ack      = admin_done_q;
    assign iosq_tail_done         = io_done_q;
    assign iosq_tail_done_ack     = io_done_q;
    assign admin_create_queue_cnt = admin_tail;
    assign io_create_queue_cnt    = io_tail;
    assign sq_full                = sq_full_q;

endmodule

// File: tb/tb_nvme_sq_writer.sv
// Directed bench for nvme_sq_writer: entry packing, queue wrap, full stall,
// ready throttling, capture isolation and mid-burst reset.
module tb_nvme_sq_writer;

    logic        clk_in = 1'b0;
    logic        resetb = 1'b0;
    logic        write_start = 1'b0;
    logic        write_start_ack;
    logic        is_io_queue = 1'b0;
    logic [7:0]  admin_opc = '0, PSDT_FUSE = '0;
    logic [15:0] cid = '0;
    logic [31:0] nsid = '0;
    logic [63:0] MPTR = '0, PRP1 = '0, PRP2 = '0;
    logic [31:0] CDW10 = '0, CDW11 = '0, CDW12 = '0, CDW13 = '0, CDW14 = '0, CDW15 = '0;
    logic [15:0] admin_sq_head = 16'd0;
    logic [15:0] io_sq_head = 16'd5;
    logic        seq_tail_done, seq_tail_done_ack, iosq_tail_done, iosq_tail_done_ack;
    logic [15:0] admin_create_queue_cnt, io_create_queue_cnt;
    logic        sq_full;

    nvme_sq_writer_if bus ();

    nvme_sq_writer dut (
        .clk_in                 (clk_in),
        .resetb                 (resetb),
        .write_start            (write_start),
        .write_start_ack        (write_start_ack),
        .is_io_queue            (is_io_queue),
        .admin_opc              (admin_opc),
        .PSDT_FUSE              (PSDT_FUSE),
        .cid                    (cid),
        .nsid                   (nsid),
        .MPTR                   (MPTR),
        .PRP1                   (PRP1),
        .PRP2                   (PRP2),
        .CDW10                  (CDW10),
        .CDW11                  (CDW11),
        .CDW12                  (CDW12),
        .CDW13                  (CDW13),
        .CDW14                  (CDW14),
        .CDW15                  (CDW15),
        .admin_sq_head          (admin_sq_head),
        .io_sq_head             (io_sq_head),
        .bus                    (bus),
        .seq_tail_done          (seq_tail_done),
        .seq_tail_done_ack      (seq_tail_done_ack),
        .iosq_tail_done         (iosq_tail_done),
        .iosq_tail_done_ack     (iosq_tail_done_ack),
        .admin_create_queue_cnt (admin_create_queue_cnt),
        .io_create_queue_cnt    (io_create_queue_cnt),
        .sq_full                (sq_full)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  e_opc, e_psdt;
    logic [15:0] e_cid;
    logic [31:0] e_nsid, e_cdw10, e_cdw11;
    logic [63:0] e_mptr, e_prp1, e_prp2;

    logic [63:0] b_addr [16];
    logic [31:0] b_data [16];
    logic [31:0] db_a, db_d;
    int beats, ack_cyc, first_cyc, last_cyc, db_cyc, done_cyc, adm_done_n, io_done_n;

    // Reference layout of a submission-queue entry, built from the expected fields.
    function automatic logic [31:0] exp_dw(input int k);
        logic [31:0] d;
        case (k)
            0:  d = {e_cid, e_psdt, e_opc};
            1:  d = e_nsid;
            4:  d = e_mptr[31:0];
            5:  d = e_mptr[63:32];
            6:  d = e_prp1[31:0];
            7:  d = e_prp1[63:32];
            8:  d = e_prp2[31:0];
            9:  d = e_prp2[63:32];
            10: d = e_cdw10;
            11: d = e_cdw11;
            12: d = e_cdw11 + 32'd1;
            13: d = e_cdw11 + 32'd2;
            14: d = e_cdw11 + 32'd3;
            15: d = e_cdw11 + 32'd4;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    task automatic set_cmd(input logic [7:0] opc, input logic [7:0] psdt, input logic [15:0] c,
                           input logic [31:0] ns, input logic [63:0] mp, input logic [63:0] p1,
                           input logic [63:0] p2, input logic [31:0] d10, input logic [31:0] d11);
        e_opc = opc; e_psdt = psdt; e_cid = c; e_nsid = ns;
        e_mptr = mp; e_prp1 = p1; e_prp2 = p2; e_cdw10 = d10; e_cdw11 = d11;
        admin_opc = opc; PSDT_FUSE = psdt; cid = c; nsid = ns;
        MPTR = mp; PRP1 = p1; PRP2 = p2; CDW10 = d10; CDW11 = d11;
        CDW12 = d11 + 32'd1; CDW13 = d11 + 32'd2; CDW14 = d11 + 32'd3; CDW15 = d11 + 32'd4;
    endtask

    task automatic scramble_inputs();
        admin_opc = ~e_opc; PSDT_FUSE = ~e_psdt; cid = ~e_cid; nsid = ~e_nsid;
        MPTR = ~e_mptr; PRP1 = ~e_prp1; PRP2 = ~e_prp2; CDW10 = ~e_cdw10; CDW11 = ~e_cdw11;
        CDW12 = 32'hdead_0012; CDW13 = 32'hdead_0013; CDW14 = 32'hdead_0014; CDW15 = 32'hdead_0015;
        is_io_queue = ~is_io_queue;
    endtask

    // Issues one command and acts as memory/doorbell slave until the done pulse ends.
    task automatic run_cmd(input logic io, input bit hold, input bit throttle,
                           input bit scramble, output bit got_ack);
        bit stall_pend, finished, seen_done;
        logic [63:0] st_addr;
        logic [31:0] st_data;
        got_ack = 0; stall_pend = 0; finished = 0; seen_done = 0;
        beats = 0; first_cyc = -1; last_cyc = -1; db_cyc = -1; done_cyc = -1;
        adm_done_n = 0; io_done_n = 0; db_a = '0; db_d = '0;
        is_io_queue = io;
        write_start = 1'b1;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk_in);
            if (write_start_ack) begin
                got_ack = 1;
                ack_cyc = cyc;
            end
        end
        if (!got_ack) begin
            write_start = 1'b0;
            return;
        end
        if (!hold) write_start = 1'b0;
        if (scramble) scramble_inputs();
        for (int i = 0; i < 600 && !finished; i++) begin
            @(negedge clk_in);
            if (stall_pend) begin
                checks++;
                if (bus.mem_wr_valid !== 1'b1 || bus.mem_wr_addr !== st_addr || bus.mem_wr_data !== st_data) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b a=%h d=%h, expected v=1 a=%h d=%h",
                             bus.mem_wr_valid, bus.mem_wr_addr, bus.mem_wr_data, st_addr, st_data);
                end
                stall_pend = 0;
            end
            checks++;
            if (bus.mem_wr_valid && bus.db_wr_valid) begin
                errors++;
                $display("[TB] FAIL valid_overlap: got mem=1 db=1, expected never both");
            end
            if (bus.mem_wr_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                bus.mem_wr_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.mem_wr_ready) begin
                    if (beats < 16) begin
                        b_addr[beats] = bus.mem_wr_addr;
                        b_data[beats] = bus.mem_wr_data;
                    end
                    beats++;
                    last_cyc = cyc;
                end else begin
                    stall_pend = 1;
                    st_addr = bus.mem_wr_addr;
                    st_data = bus.mem_wr_data;
                end
            end
            if (bus.db_wr_valid && bus.db_wr_ready) begin
                db_cyc = cyc;
                db_a = bus.db_wr_addr;
                db_d = bus.db_wr_data;
            end
            if (seq_tail_done || iosq_tail_done || seq_tail_done_ack || iosq_tail_done_ack) begin
                seen_done = 1;
                if (done_cyc < 0) done_cyc = cyc;
                if (seq_tail_done) adm_done_n++;
                if (iosq_tail_done) io_done_n++;
                checks++;
                if (seq_tail_done !== seq_tail_done_ack || iosq_tail_done !== iosq_tail_done_ack) begin
                    errors++;
                    $display("[TB] FAIL done_pair: got seq=%b/%b io=%b/%b, expected matching pairs",
                             seq_tail_done, seq_tail_done_ack, iosq_tail_done, iosq_tail_done_ack);
                end
            end else if (seen_done) begin
                finished = 1;
            end
        end
        bus.mem_wr_ready = 1'b1;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_timeout: got no completed done pulse, expected one within 600 cycles");
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        checks++;
        if ({write_start_ack, bus.mem_wr_valid, bus.db_wr_valid, seq_tail_done, seq_tail_done_ack,
             iosq_tail_done, iosq_tail_done_ack, sq_full} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ack/mv/dv/sd/sa/id/ia/full=%b%b%b%b%b%b%b%b, expected 00000000",
                     write_start_ack, bus.mem_wr_valid, bus.db_wr_valid, seq_tail_done, seq_tail_done_ack,
                     iosq_tail_done, iosq_tail_done_ack, sq_full);
        end
        checks++;
        if (admin_create_queue_cnt !== 16'd0 || io_create_queue_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_tails: got %0d/%0d, expected 0/0", admin_create_queue_cnt, io_create_queue_cnt);
        end
        checks++;
        if (bus.mem_wr_addr !== 64'd0 || bus.mem_wr_data !== 32'd0 || bus.db_wr_addr !== 32'd0 || bus.db_wr_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got ma=%h md=%h da=%h dd=%h, expected all 0",
                     bus.mem_wr_addr, bus.mem_wr_data, bus.db_wr_addr, bus.db_wr_data);
        end
        resetb = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_identify();
        bit ok, extra_ack;
        set_cmd(8'h06, 8'h00, 16'h0000, 32'h0, 64'h0, 64'h0000_0000_a010_4000, 64'h0, 32'd1, 32'd0);
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || beats !== 16) begin
            errors++;
            $display("[TB] FAIL identify_beats: got ack=%0d beats=%0d, expected ack=1 beats=16", ok, beats);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (b_addr[k] !== 64'h0000_0000_a010_0000 + 64'(4 * k) || b_data[k] !== exp_dw(k)) begin
                errors++;
                $display("[TB] FAIL identify_dw%0d: got a=%h d=%h, expected a=%h d=%h", k, b_addr[k], b_data[k],
                         64'h0000_0000_a010_0000 + 64'(4 * k), exp_dw(k));
            end
        end
        checks++;
        if (b_data[0] !== 32'h0000_0006 || b_data[6] !== 32'ha010_4000 || b_data[10] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL identify_fields: got dw0=%h dw6=%h dw10=%h, expected 00000006 a0104000 00000001",
                     b_data[0], b_data[6], b_data[10]);
        end
        checks++;
        if (first_cyc - ack_cyc !== 2 || last_cyc - first_cyc !== 15 || db_cyc - last_cyc !== 1 || done_cyc - db_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL identify_timing: got ack->v=%0d burst=%0d last->db=%0d db->done=%0d, expected 2 15 1 1",
                     first_cyc - ack_cyc, last_cyc - first_cyc, db_cyc - last_cyc, done_cyc - db_cyc);
        end
        checks++;
        if (db_a !== 32'h0000_1000 || db_d !== 32'd1) begin
            errors++;
            $display("[TB] FAIL identify_doorbell: got a=%h d=%h, expected a=00001000 d=00000001", db_a, db_d);
        end
        checks++;
        if (adm_done_n !== 1 || io_done_n !== 0 || admin_create_queue_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL identify_done: got adm=%0d io=%0d tail=%0d, expected 1 0 1",
                     adm_done_n, io_done_n, admin_create_queue_cnt);
        end
        extra_ack = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (write_start_ack) extra_ack = 1;
        end
        checks++;
        if (extra_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_request: got second ack, expected none while request held");
        end
        write_start = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_io_full();
        bit ok, all_ok, seen_ack;
        all_ok = 1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(8'h01, 8'h00, 16'(i), 32'd1, 64'h0, 64'h1000 * 64'(i), 64'h0, 32'd0, 32'd0);
            run_cmd(1'b1, 1'b0, 1'b0, 1'b0, ok);
            if (!ok) all_ok = 0;
        end
        checks++;
        if (!all_ok || io_create_queue_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL io_fill: got all_ack=%0d tail=%0d, expected 1 4", all_ok, io_create_queue_cnt);
        end
        set_cmd(8'h02, 8'h00, 16'h0055, 32'd1, 64'h0, 64'h0000_0001_0000_0000, 64'h0, 32'h10, 32'h20);
        is_io_queue = 1'b1;
        write_start = 1'b1;
        seen_ack = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (write_start_ack) seen_ack = 1;
        end
        checks++;
        if (seen_ack !== 1'b0 || sq_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL io_full: got ack=%0d sq_full=%b, expected ack=0 sq_full=1", seen_ack, sq_full);
        end
        io_sq_head = 16'd6;
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || io_create_queue_cnt !== 16'd5 || db_d !== 32'd5 || io_done_n !== 1 || sq_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL io_unblock: got ack=%0d tail=%0d db=%0d done=%0d full=%b, expected 1 5 5 1 0",
                     ok, io_create_queue_cnt, db_d, io_done_n, sq_full);
        end
        checks++;
        if (b_addr[0] !== 64'h0000_0000_a010_2100 || b_data[0] !== 32'h0055_0002) begin
            errors++;
            $display("[TB] FAIL io_unblock_entry: got a=%h d=%h, expected a=00000000a0102100 d=00550002", b_addr[0], b_data[0]);
        end
    endtask

    task automatic test_io_wrap();
        bit ok, all_ok;
        io_sq_head = 16'd1;
        all_ok = 1;
        for (int i = 0; i < 58; i++) begin
            set_cmd(8'h01, 8'h00, 16'(i), 32'd1, 64'h0, 64'h0, 64'h0, 32'd0, 32'd0);
            run_cmd(1'b1, 1'b0, 1'b0, 1'b0, ok);
            if (!ok) all_ok = 0;
        end
        checks++;
        if (!all_ok || io_create_queue_cnt !== 16'd63) begin
            errors++;
            $display("[TB] FAIL io_advance: got all_ack=%0d tail=%0d, expected 1 63", all_ok, io_create_queue_cnt);
        end
        set_cmd(8'h02, 8'h40, 16'h003f, 32'h0000_0001, 64'h1122_3344_5566_7788,
                64'h0000_0002_0000_1000, 64'h0000_0002_0000_2000, 32'h0000_0400, 32'h8000_0000);
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, ok);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (b_addr[k] !== 64'h0000_0000_a010_2fc0 + 64'(4 * k) || b_data[k] !== exp_dw(k)) begin
                errors++;
                $display("[TB] FAIL wrap_dw%0d: got a=%h d=%h, expected a=%h d=%h", k, b_addr[k], b_data[k],
                         64'h0000_0000_a010_2fc0 + 64'(4 * k), exp_dw(k));
            end
        end
        checks++;
        if (!ok || db_a !== 32'h0000_1008 || db_d !== 32'd0 || io_create_queue_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL wrap_doorbell: got ack=%0d a=%h d=%h tail=%0d, expected 1 00001008 0 0",
                     ok, db_a, db_d, io_create_queue_cnt);
        end
        checks++;
        if (io_done_n !== 1 || adm_done_n !== 0 || admin_create_queue_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL wrap_done: got io=%0d adm=%0d admin_tail=%0d, expected 1 0 1",
                     io_done_n, adm_done_n, admin_create_queue_cnt);
        end
    endtask

    task automatic test_throttle();
        bit ok;
        set_cmd(8'h09, 8'h01, 16'h1234, 32'hcafe_f00d, 64'h0123_4567_89ab_cdef,
                64'h0000_0003_0000_0000, 64'h0000_0004_0000_0000, 32'h5a5a_5a5a, 32'h0000_1000);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0, ok);
        checks++;
        if (!ok || beats !== 16 || db_cyc <= last_cyc) begin
            errors++;
            $display("[TB] FAIL throttle_order: got ack=%0d beats=%0d db_cyc=%0d last=%0d, expected 1 16 db after last",
                     ok, beats, db_cyc, last_cyc);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (b_addr[k] !== 64'h0000_0000_a010_0040 + 64'(4 * k) || b_data[k] !== exp_dw(k)) begin
                errors++;
                $display("[TB] FAIL throttle_dw%0d: got a=%h d=%h, expected a=%h d=%h", k, b_addr[k], b_data[k],
                         64'h0000_0000_a010_0040 + 64'(4 * k), exp_dw(k));
            end
        end
        checks++;
        if (db_d !== 32'd2 || admin_create_queue_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL throttle_tail: got db=%0d tail=%0d, expected 2 2", db_d, admin_create_queue_cnt);
        end
    endtask

    task automatic test_capture_isolation();
        bit ok;
        set_cmd(8'h0a, 8'h02, 16'h0bee, 32'h0000_0007, 64'haaaa_bbbb_cccc_dddd,
                64'h0000_0005_0000_0000, 64'h0000_0006_0000_0000, 32'h0000_0011, 32'h0000_0020);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b1, ok);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (b_addr[k] !== 64'h0000_0000_a010_0080 + 64'(4 * k) || b_data[k] !== exp_dw(k)) begin
                errors++;
                $display("[TB] FAIL capture_dw%0d: got a=%h d=%h, expected a=%h d=%h", k, b_addr[k], b_data[k],
                         64'h0000_0000_a010_0080 + 64'(4 * k), exp_dw(k));
            end
        end
        checks++;
        if (!ok || db_d !== 32'd3 || adm_done_n !== 1 || io_done_n !== 0 || admin_create_queue_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL capture_queue: got ack=%0d db=%0d adm=%0d io=%0d tail=%0d, expected 1 3 1 0 3",
                     ok, db_d, adm_done_n, io_done_n, admin_create_queue_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, got, stray;
        int n;
        set_cmd(8'h06, 8'h00, 16'h0777, 32'h0, 64'h0, 64'h0000_0000_a010_8000, 64'h0, 32'd2, 32'd0);
        is_io_queue = 1'b0;
        write_start = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_in);
            if (write_start_ack) got = 1;
        end
        write_start = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            @(negedge clk_in);
            if (bus.mem_wr_valid) n++;
        end
        checks++;
        if (!got || n !== 8) begin
            errors++;
            $display("[TB] FAIL midreset_setup: got ack=%0d beats=%0d, expected 1 8", got, n);
        end
        @(negedge clk_in);
        resetb = 1'b0;
        #1;
        checks++;
        if (bus.mem_wr_valid !== 1'b0 || bus.mem_wr_addr !== 64'd0 || bus.mem_wr_data !== 32'd0 ||
            bus.db_wr_valid !== 1'b0 || admin_create_queue_cnt !== 16'd0 || io_create_queue_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got mv=%b ma=%h md=%h dv=%b tails=%0d/%0d, expected all 0",
                     bus.mem_wr_valid, bus.mem_wr_addr, bus.mem_wr_data, bus.db_wr_valid,
                     admin_create_queue_cnt, io_create_queue_cnt);
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (bus.mem_wr_valid || bus.db_wr_valid) stray = 1;
        end
        resetb = 1'b1;
        repeat (2) begin
            @(negedge clk_in);
            if (bus.mem_wr_valid || bus.db_wr_valid) stray = 1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got write activity after reset, expected none");
        end
        set_cmd(8'h06, 8'h00, 16'h0001, 32'h0, 64'h0, 64'h0000_0000_a010_9000, 64'h0, 32'd1, 32'd0);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || b_addr[0] !== 64'h0000_0000_a010_0000 || b_addr[15] !== 64'h0000_0000_a010_003c ||
            db_d !== 32'd1 || admin_create_queue_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got ack=%0d a0=%h a15=%h db=%0d tail=%0d, expected 1 a0100000 a010003c 1 1",
                     ok, b_addr[0], b_addr[15], db_d, admin_create_queue_cnt);
        end
    endtask

    initial begin
        bus.mem_wr_ready = 1'b1;
        bus.db_wr_ready  = 1'b1;
        $display("[TB] nvme_sq_writer bench start");
        test_reset();
        test_identify();
        test_io_full();
        test_io_wrap();
        test_throttle();
        test_capture_isolation();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
